// File: rtl/dmem_responder.sv
// dmem_responder: handshaked word data memory with programmable wait states.
// Optional misaligned-access error reporting is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [AW-1:0] r_word;
  logic [31:0]   r_wdata;
  logic          r_mis;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_live;
  logic          w_accept;
  logic          w_enter;
  logic          w_commit;
  logic          w_write;
  logic [AW-1:0] w_word;
  logic [31:0]   w_wdata;
  logic          w_mis_in;
  logic          w_mis;
  logic          w_unused;

  // The word index keeps only the bits inside the array, so higher address bits wrap.
  assign w_unused = ^{req_addr[31:AW+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis_in = |req_addr[1:0];
`else
  assign w_mis_in = 1'b0;
`endif

  // With zero wait states the access happens on the accept edge, so the live request
  // fields are used while idle and the latched ones otherwise.
  assign w_live    = (r_state == IDLE);
  assign w_accept  = w_live & req_valid;
  assign w_write   = w_live ? req_write : r_write;
  assign w_word    = w_live ? req_addr[AW+1:2] : r_word;
  assign w_wdata   = w_live ? req_wdata : r_wdata;
  assign w_mis     = w_live ? w_mis_in : r_mis;
  assign w_enter   = (WAIT_CYCLES == 0) ? w_accept : (r_state == WAIT && r_cnt == 4'd1);
  assign w_commit  = RST & w_enter & w_write & ~w_mis;

  assign req_ready = (r_state == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Store commit on the edge that enters RESP; a store dropped by reset never reaches it.
  always_ff @(posedge CLK) begin
    if (w_commit) r_mem[w_word] <= w_wdata;
  end

  // Request/wait/response sequencing with registered response data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_mis   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_write <= req_write;
          r_word  <= req_addr[AW+1:2];
          r_wdata <= req_wdata;
          r_mis   <= w_mis_in;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_enter) begin
        r_rdata <= (w_write | w_mis) ? 32'd0 : r_mem[w_word];
        r_err   <= w_mis;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder, one instance with 2 wait states, one with 0.
module tb_dmem_responder;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = '0;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] rsp_rdata [2];
  logic [1:0]  rsp_err;
  logic [1:0]  busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc [2];
  bit   seen [2];
  exp_t cur [2];
  exp_t q0 [$];
  exp_t q1 [$];

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response when a DUT first presents one, then checks it
  // every cycle it is held, including the consuming cycle.
  task automatic mon(int d);
    if (!RST) begin
      seen[d] = 1'b0;
      return;
    end
    if (req_valid[d] && req_ready[d]) acc[d] = cyc;
    if (!rsp_valid[d]) return;
    if (!seen[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp dut%0d: got a response, expected none", d);
        return;
      end
      if (d == 0) cur[d] = q0.pop_front();
      else cur[d] = q1.pop_front();
      seen[d] = 1'b1;
      chk($sformatf("latency dut%0d", d), 32'(cyc - acc[d] - 1), 32'(cur[d].lat));
    end
    chk($sformatf("rdata dut%0d", d), rsp_rdata[d], cur[d].rdata);
    chk($sformatf("err dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, cur[d].err});
    if (rsp_ready[d]) seen[d] = 1'b0;
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic txn(int d, bit wr, logic [31:0] addr, logic [31:0] wdata,
                     logic [31:0] exp_rdata, bit exp_err, int hold);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = (d == 0) ? 2 : 0;
    @(posedge CLK); #1;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge CLK); #1;
    req_valid[d] = 1'b0;
    for (int n = 0; n < 40 && !rsp_valid[d]; n++) begin
      @(posedge CLK); #1;
    end
    if (!rsp_valid[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout dut%0d: got no response, expected rsp_valid", d);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("bp_req_ready", {31'd0, req_ready[d]}, 32'd0);
      chk("bp_busy", {31'd0, busy[d]}, 32'd1);
      req_valid[d] = (h == 1);
      req_write[d] = 1'b1;
      req_addr[d]  = 32'h10;
      req_wdata[d] = 32'h0BAD_0BAD;
      @(posedge CLK); #1;
      req_valid[d] = 1'b0;
      chk("bp_rsp_valid", {31'd0, rsp_valid[d]}, 32'd1);
    end
    rsp_ready[d] = 1'b1;
    @(posedge CLK); #1;
    rsp_ready[d] = 1'b0;
    chk("post_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready[d]}, 32'd1);
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      acc[d]       = 0;
      seen[d]      = 1'b0;
    end
    #1;
    chk_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    // Store then load with two wait states, plus an aliased address that wraps onto 0x10.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    txn(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    txn(0, 1'b0, 32'h410, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    // Backpressure with a pulsed store to 0x10 that must be ignored.
    txn(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);
    txn(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    // Zero wait states and wrap modulo DEPTH*4.
    txn(1, 1'b1, 32'h400, 32'h1234, 32'd0, 1'b0, 0);
    txn(1, 1'b0, 32'h000, 32'd0, 32'h1234, 1'b0, 0);
    txn(1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
    txn(1, 1'b0, 32'h3FC, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
    // Reset during WAIT drops the store; outputs clear asynchronously.
    txn(0, 1'b1, 32'h20, 32'hAAAA_5555, 32'd0, 1'b0, 0);
    txn(0, 1'b0, 32'h20, 32'd0, 32'hAAAA_5555, 1'b0, 0);
    @(posedge CLK); #1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h1;
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    @(posedge CLK); #1;
    chk("wait_busy", {31'd0, busy[0]}, 32'd1);
    RST = 1'b0;
    #1;
    chk_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    txn(0, 1'b0, 32'h20, 32'd0, 32'hAAAA_5555, 1'b0, 0);
    // Misaligned store: error and no write only with the alignment check built in.
    txn(0, 1'b1, 32'h13, 32'hFFFF_FFFF, 32'd0, ALIGN, 0);
    txn(0, 1'b0, 32'h10, 32'd0, ALIGN ? 32'hDEAD_BEEF : 32'hFFFF_FFFF, 1'b0, 0);
    repeat (3) @(posedge CLK);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
